// File: rtl/vscale_wb_arbiter.sv
// vscale_wb_arbiter: merges pipeline writebacks with buffered mul/div results onto the regfile write port
// Ports:
//   clk, reset                 clock, async active-high reset
//   pipe_wen/wa/wd             pipeline writeback request
//   md_issue/_wa, md_issue_ready   mul/div issue handshake (blocked while destination busy)
//   md_resp_valid/wa/wd, md_resp_ready   mul/div result handshake (ready = buffer not full)
//   ra1, ra2, hazard1, hazard2 decode source addresses and busy flags
//   rf_wen/wa/wd               registered regfile write port
module vscale_wb_arbiter #(
    parameter int XPR_LEN        = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int MD_DEPTH       = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      pipe_wen,
    input  logic [REG_ADDR_WIDTH-1:0] pipe_wa,
    input  logic [XPR_LEN-1:0]        pipe_wd,
    input  logic                      md_issue,
    input  logic [REG_ADDR_WIDTH-1:0] md_issue_wa,
    output logic                      md_issue_ready,
    input  logic                      md_resp_valid,
    input  logic [REG_ADDR_WIDTH-1:0] md_resp_wa,
    input  logic [XPR_LEN-1:0]        md_resp_wd,
    output logic                      md_resp_ready,
    input  logic [REG_ADDR_WIDTH-1:0] ra1,
    input  logic [REG_ADDR_WIDTH-1:0] ra2,
    output logic                      hazard1,
    output logic                      hazard2,
    output logic                      rf_wen,
    output logic [REG_ADDR_WIDTH-1:0] rf_wa,
    output logic [XPR_LEN-1:0]        rf_wd
);
    localparam int PW   = $clog2(MD_DEPTH);
    localparam int NREG = 1 << REG_ADDR_WIDTH;

    logic [REG_ADDR_WIDTH-1:0] fifo_wa_q [MD_DEPTH];
    logic [XPR_LEN-1:0]        fifo_wd_q [MD_DEPTH];
    logic [PW-1:0]             rd_ptr_q, wr_ptr_q;
    logic [PW:0]               count_q, count_d;
    logic [NREG-1:0]           busy_q, busy_d;
    logic                      rf_wen_q, rf_src_md_q;
    logic [REG_ADDR_WIDTH-1:0] rf_wa_q, rf_wa_d;
    logic [XPR_LEN-1:0]        rf_wd_q, rf_wd_d;
    logic pipe_eff, fifo_empty, md_keep, sel_fifo, sel_direct, push, pop, wen_d;

    assign pipe_eff       = pipe_wen && |pipe_wa;
    assign fifo_empty     = count_q == '0;
    assign md_resp_ready  = count_q != (PW+1)'(MD_DEPTH);
    // x0 results are accepted but never buffered or written
    assign md_keep        = md_resp_valid && md_resp_ready && |md_resp_wa;
    assign sel_fifo       = !pipe_eff && !fifo_empty;
    assign sel_direct     = !pipe_eff && fifo_empty && md_keep;
    assign push           = md_keep && !sel_direct;
    assign pop            = sel_fifo;
    assign wen_d          = pipe_eff || sel_fifo || sel_direct;
    assign count_d        = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    assign md_issue_ready = !busy_q[md_issue_wa];
    assign hazard1        = busy_q[ra1];
    assign hazard2        = busy_q[ra2];
    assign rf_wen         = rf_wen_q;
    assign rf_wa          = rf_wa_q;
    assign rf_wd          = rf_wd_q;

    always_comb begin
        rf_wa_d = pipe_eff ? pipe_wa : sel_fifo ? fifo_wa_q[rd_ptr_q] : md_resp_wa;
        rf_wd_d = pipe_eff ? pipe_wd : sel_fifo ? fifo_wd_q[rd_ptr_q] : md_resp_wd;
    end

    // Busy clears on the same edge the regfile absorbs the mul/div value
    always_comb begin
        busy_d = busy_q;
        if (rf_wen_q && rf_src_md_q) busy_d[rf_wa_q] = 1'b0;
        if (md_issue && md_issue_ready) busy_d[md_issue_wa] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            busy_q      <= '0;
            rf_wen_q    <= 1'b0;
            rf_src_md_q <= 1'b0;
            rf_wa_q     <= '0;
            rf_wd_q     <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_q + PW'(pop);
            wr_ptr_q    <= wr_ptr_q + PW'(push);
            count_q     <= count_d;
            busy_q      <= busy_d;
            rf_wen_q    <= wen_d;
            rf_src_md_q <= sel_fifo || sel_direct;
            if (wen_d) begin
                rf_wa_q <= rf_wa_d;
                rf_wd_q <= rf_wd_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_wa_q[wr_ptr_q] <= md_resp_wa;
            fifo_wd_q[wr_ptr_q] <= md_resp_wd;
        end
    end
endmodule

// File: tb/tb_vscale_wb_arbiter.sv
// tb_vscale_wb_arbiter: directed scenario bench for the writeback arbiter
module tb_vscale_wb_arbiter;
    logic        clk = 1'b0, reset = 1'b1;
    logic        pipe_wen, md_issue, md_resp_valid;
    logic [4:0]  pipe_wa, md_issue_wa, md_resp_wa, ra1, ra2;
    logic [31:0] pipe_wd, md_resp_wd;
    logic        md_issue_ready, md_resp_ready, hazard1, hazard2, rf_wen;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    int total = 0, bad = 0;

    vscale_wb_arbiter dut (
        .clk(clk), .reset(reset),
        .pipe_wen(pipe_wen), .pipe_wa(pipe_wa), .pipe_wd(pipe_wd),
        .md_issue(md_issue), .md_issue_wa(md_issue_wa), .md_issue_ready(md_issue_ready),
        .md_resp_valid(md_resp_valid), .md_resp_wa(md_resp_wa), .md_resp_wd(md_resp_wd),
        .md_resp_ready(md_resp_ready),
        .ra1(ra1), .ra2(ra2), .hazard1(hazard1), .hazard2(hazard2),
        .rf_wen(rf_wen), .rf_wa(rf_wa), .rf_wd(rf_wd)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pipe_wen = 0; pipe_wa = 0; pipe_wd = 0;
        md_issue = 0; md_issue_wa = 0;
        md_resp_valid = 0; md_resp_wa = 0; md_resp_wd = 0;
        ra1 = 0; ra2 = 0;
    endtask

    task automatic pipe(input logic [4:0] wa, input logic [31:0] wd);
        pipe_wen = 1; pipe_wa = wa; pipe_wd = wd;
    endtask

    task automatic resp(input logic [4:0] wa, input logic [31:0] wd);
        md_resp_valid = 1; md_resp_wa = wa; md_resp_wd = wd;
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        tick(); tick();
        total++; if (rf_wen !== 1'b0) begin bad++; $display("FAIL reset_wen got=%b exp=0", rf_wen); end
        total++; if (rf_wa !== 5'd0) begin bad++; $display("FAIL reset_wa got=%0d exp=0", rf_wa); end
        total++; if (rf_wd !== 32'd0) begin bad++; $display("FAIL reset_wd got=%h exp=0", rf_wd); end
        total++; if (md_resp_ready !== 1'b1) begin bad++; $display("FAIL reset_resp_ready got=%b exp=1", md_resp_ready); end
        total++; if (md_issue_ready !== 1'b1) begin bad++; $display("FAIL reset_issue_ready got=%b exp=1", md_issue_ready); end
        total++; if ({hazard1, hazard2} !== 2'b00) begin bad++; $display("FAIL reset_hazard got=%b exp=00", {hazard1, hazard2}); end
        reset = 0;
        tick();
    endtask

    task automatic test_md_basic();
        idle();
        md_issue = 1; md_issue_wa = 7; ra1 = 7;
        #1;
        total++; if (md_issue_ready !== 1'b1) begin bad++; $display("FAIL md_issue_ready7 got=%b exp=1", md_issue_ready); end
        tick();
        md_issue = 0;
        #1;
        total++; if (hazard1 !== 1'b1) begin bad++; $display("FAIL md_hazard_after_issue got=%b exp=1", hazard1); end
        resp(7, 32'hDEADBEEF);
        #1;
        total++; if (md_resp_ready !== 1'b1) begin bad++; $display("FAIL md_resp_ready got=%b exp=1", md_resp_ready); end
        tick();
        md_resp_valid = 0;
        total++; if ({rf_wen, rf_wa, rf_wd} !== {1'b1, 5'd7, 32'hDEADBEEF}) begin bad++; $display("FAIL md_write got=%b/%0d/%h exp=1/7/deadbeef", rf_wen, rf_wa, rf_wd); end
        total++; if (hazard1 !== 1'b1) begin bad++; $display("FAIL md_hazard_during_write got=%b exp=1", hazard1); end
        tick();
        total++; if (hazard1 !== 1'b0) begin bad++; $display("FAIL md_hazard_cleared got=%b exp=0", hazard1); end
        total++; if (rf_wen !== 1'b0) begin bad++; $display("FAIL md_wen_drop got=%b exp=0", rf_wen); end
    endtask

    task automatic test_contention();
        idle();
        pipe(3, 32'h11); resp(9, 32'h22);
        tick();
        idle();
        total++; if ({rf_wen, rf_wa, rf_wd} !== {1'b1, 5'd3, 32'h11}) begin bad++; $display("FAIL cont_pipe got=%b/%0d/%h exp=1/3/11", rf_wen, rf_wa, rf_wd); end
        tick();
        total++; if ({rf_wen, rf_wa, rf_wd} !== {1'b1, 5'd9, 32'h22}) begin bad++; $display("FAIL cont_md got=%b/%0d/%h exp=1/9/22", rf_wen, rf_wa, rf_wd); end
        tick();
        total++; if (rf_wen !== 1'b0) begin bad++; $display("FAIL cont_idle got=%b exp=0", rf_wen); end
    endtask

    task automatic test_back_to_back();
        idle();
        pipe(1, 32'hA1); resp(10, 32'h100);
        #1;
        total++; if (md_resp_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready0 got=%b exp=1", md_resp_ready); end
        tick();
        total++; if ({rf_wen, rf_wa} !== {1'b1, 5'd1}) begin bad++; $display("FAIL b2b_pipe1 got=%b/%0d exp=1/1", rf_wen, rf_wa); end
        pipe(2, 32'hA2); resp(11, 32'h110);
        #1;
        total++; if (md_resp_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready1 got=%b exp=1", md_resp_ready); end
        tick();
        pipe(3, 32'hA3); resp(12, 32'h120);
        #1;
        total++; if (md_resp_ready !== 1'b0) begin bad++; $display("FAIL b2b_full got=%b exp=0", md_resp_ready); end
        tick();
        total++; if ({rf_wen, rf_wa, rf_wd} !== {1'b1, 5'd3, 32'hA3}) begin bad++; $display("FAIL b2b_pipe3 got=%b/%0d/%h exp=1/3/a3", rf_wen, rf_wa, rf_wd); end
        pipe(4, 32'hA4);
        tick();
        pipe_wen = 0;
        #1;
        total++; if (md_resp_ready !== 1'b0) begin bad++; $display("FAIL b2b_full_pop got=%b exp=0", md_resp_ready); end
        tick();
        total++; if ({rf_wen, rf_wa, rf_wd} !== {1'b1, 5'd10, 32'h100}) begin bad++; $display("FAIL b2b_drain10 got=%b/%0d/%h exp=1/10/100", rf_wen, rf_wa, rf_wd); end
        total++; if (md_resp_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_again got=%b exp=1", md_resp_ready); end
        tick();
        md_resp_valid = 0;
        total++; if ({rf_wen, rf_wa, rf_wd} !== {1'b1, 5'd11, 32'h110}) begin bad++; $display("FAIL b2b_drain11 got=%b/%0d/%h exp=1/11/110", rf_wen, rf_wa, rf_wd); end
        tick();
        total++; if ({rf_wen, rf_wa, rf_wd} !== {1'b1, 5'd12, 32'h120}) begin bad++; $display("FAIL b2b_drain12 got=%b/%0d/%h exp=1/12/120", rf_wen, rf_wa, rf_wd); end
        tick();
        total++; if (rf_wen !== 1'b0) begin bad++; $display("FAIL b2b_empty got=%b exp=0", rf_wen); end
    endtask

    task automatic test_issue_busy();
        idle();
        md_issue = 1; md_issue_wa = 4;
        tick();
        ra1 = 4;
        #1;
        total++; if (md_issue_ready !== 1'b0) begin bad++; $display("FAIL busy_issue_ready got=%b exp=0", md_issue_ready); end
        tick();
        total++; if (hazard1 !== 1'b1) begin bad++; $display("FAIL busy_still got=%b exp=1", hazard1); end
        md_issue_wa = 0; ra2 = 0;
        #1;
        total++; if (md_issue_ready !== 1'b1) begin bad++; $display("FAIL x0_issue_ready got=%b exp=1", md_issue_ready); end
        tick();
        md_issue = 0;
        total++; if (hazard2 !== 1'b0) begin bad++; $display("FAIL x0_not_busy got=%b exp=0", hazard2); end
        resp(4, 32'h44);
        tick();
        md_resp_valid = 0;
        tick();
        total++; if (hazard1 !== 1'b0) begin bad++; $display("FAIL busy4_cleared got=%b exp=0", hazard1); end
    endtask

    task automatic test_x0_writes();
        idle();
        pipe(5, 32'h55); resp(6, 32'h66);
        tick();
        idle();
        pipe(0, 32'hFF);
        tick();
        total++; if ({rf_wen, rf_wa, rf_wd} !== {1'b1, 5'd6, 32'h66}) begin bad++; $display("FAIL x0_head got=%b/%0d/%h exp=1/6/66", rf_wen, rf_wa, rf_wd); end
        tick();
        total++; if ({rf_wen, rf_wa, rf_wd} !== {1'b0, 5'd6, 32'h66}) begin bad++; $display("FAIL x0_pipe_drop got=%b/%0d/%h exp=0/6/66", rf_wen, rf_wa, rf_wd); end
        idle();
        resp(0, 32'hBAD);
        #1;
        total++; if (md_resp_ready !== 1'b1) begin bad++; $display("FAIL x0_resp_ready got=%b exp=1", md_resp_ready); end
        tick();
        idle();
        total++; if (rf_wen !== 1'b0) begin bad++; $display("FAIL x0_resp_drop got=%b exp=0", rf_wen); end
        tick();
        total++; if (rf_wen !== 1'b0) begin bad++; $display("FAIL x0_resp_not_buffered got=%b exp=0", rf_wen); end
    endtask

    task automatic test_reset_mid();
        idle();
        md_issue = 1; md_issue_wa = 5;
        tick();
        md_issue = 0;
        pipe(1, 32'h1); resp(20, 32'h200);
        tick();
        pipe(2, 32'h2); resp(21, 32'h210);
        tick();
        idle();
        ra1 = 5;
        #1;
        total++; if ({md_resp_ready, hazard1} !== 2'b01) begin bad++; $display("FAIL pre_reset got=%b exp=01", {md_resp_ready, hazard1}); end
        reset = 1;
        #1;
        total++; if (rf_wen !== 1'b0) begin bad++; $display("FAIL async_reset_wen got=%b exp=0", rf_wen); end
        total++; if (md_resp_ready !== 1'b1) begin bad++; $display("FAIL async_reset_ready got=%b exp=1", md_resp_ready); end
        total++; if (hazard1 !== 1'b0) begin bad++; $display("FAIL async_reset_hazard got=%b exp=0", hazard1); end
        #1;
        reset = 0;
        tick();
        total++; if (rf_wen !== 1'b0) begin bad++; $display("FAIL reset_fifo_lost got=%b exp=0", rf_wen); end
        tick();
        total++; if (rf_wen !== 1'b0) begin bad++; $display("FAIL reset_fifo_lost2 got=%b exp=0", rf_wen); end
    endtask

    initial begin
        test_reset();
        test_md_basic();
        test_contention();
        test_back_to_back();
        test_issue_busy();
        test_x0_writes();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vscale_wb_arbiter.md
# vscale_wb_arbiter

Writeback arbiter between the execute/memory pipeline and the register file write port. It merges same-cycle pipeline writes with out-of-band results from the multicycle mul/div unit, buffering mul/div results in a small FIFO while the pipeline holds the port. It also keeps a 32-entry busy scoreboard for outstanding mul/div destinations and drives operand hazard flags for decode. Its registered outputs drive `wen`/`wa`/`wd` of `vscale_regfile` directly.

## Interface
- `XPR_LEN`, 32, data width
- `REG_ADDR_WIDTH`, 5, register address width
- `MD_DEPTH`, 2, mul/div result buffer depth (power of 2, ≥2)

Ports:
- `clk` input 1: clock, all state on rising edge
- `reset` input 1: asynchronous, active-high reset
- `pipe_wen` input 1: pipeline writeback valid
- `pipe_wa` input REG_ADDR_WIDTH: pipeline destination
- `pipe_wd` input XPR_LEN: pipeline write data
- `md_issue` input 1: mul/div op issued this cycle
- `md_issue_wa` input REG_ADDR_WIDTH: destination of issued op
- `md_issue_ready` output 1: issue allowed (destination not busy)
- `md_resp_valid` input 1: mul/div result valid
- `md_resp_wa` input REG_ADDR_WIDTH: result destination
- `md_resp_wd` input XPR_LEN: result data
- `md_resp_ready` output 1: result accepted when high with valid
- `ra1`, `ra2` input REG_ADDR_WIDTH: decode source addresses
- `hazard1`, `hazard2` output 1: source is busy, decode must stall
- `rf_wen` output 1: regfile write enable (registered)
- `rf_wa` output REG_ADDR_WIDTH: regfile write address (registered)
- `rf_wd` output XPR_LEN: regfile write data (registered)

## Operation
- Pipe write effective when `pipe_wen && |pipe_wa`; writes to x0 are dropped and do not occupy the port.
- Port selection each cycle, priority order: (1) effective pipe write; (2) FIFO head; (3) incoming accepted mul/div response directly (only when FIFO empty). Selected write is registered into `rf_*` with `rf_wen`=1; otherwise `rf_wen`=0, `rf_wa`/`rf_wd` hold.
- Accepted response (`md_resp_valid && md_resp_ready`) not selected directly is pushed to FIFO tail. Order of mul/div results preserved.
- `md_resp_ready` = FIFO not full (combinational from state only, not from `pipe_wen`).
- Push and pop same cycle allowed when non-full; full with pop: ready still low that cycle (ready depends on count only).
- Responses to x0 accepted and discarded (never reach `rf_*`).
- Internal `rf_src_md` flag registered alongside `rf_*`, marks write as mul/div-sourced.
- Scoreboard `busy[31:1]`, `busy[0]`=0 always.
  - Set: `md_issue && md_issue_ready && |md_issue_wa` sets `busy[md_issue_wa]`.
  - Clear: on the edge where regfile commits an md write, i.e. when `rf_wen && rf_src_md` is high, clear `busy[rf_wa]`.
  - Set and clear of different registers same edge both take effect; same register cannot occur (issue_ready low while busy).
- `md_issue_ready` = `!busy[md_issue_wa]` (x0 always ready).
- `hazard1` = `busy[ra1]`, `hazard2` = `busy[ra2]`, combinational.
- Pipe write to a busy register is a protocol violation (decode prevents it); arbiter behaviour then is undefined for ordering but must not corrupt FIFO state.

## Timing
- Reset (async assert, any time): `rf_wen`=0, `rf_wa`=0, `rf_wd`=0, `rf_src_md`=0, FIFO empty, all busy=0; hence `md_resp_ready`=1, `md_issue_ready`=1, `hazard*`=0. In-flight buffered results are lost.
- Pipe write: `rf_wen` high 1 cycle after `pipe_wen`; regfile updated at following edge.
- Mul/div response, uncontended: `rf_wen` 1 cycle after acceptance; busy bit clears at next edge (same edge regfile written), so `hazard` drops 2 cycles after acceptance.
- Each cycle a pipe write is present adds 1 cycle of delay to buffered results.
- Deassert of `hazard` coincides with the edge the regfile contains the value; no forwarding required.

## Test plan
- Reset mid-operation with FIFO holding 2 entries and busy[5]=1 -> immediately `rf_wen`=0, `md_resp_ready`=1, `hazard1`=0 for `ra1`=5.
- Issue md to x7, response 0xDEADBEEF to x7 with no pipe write -> `rf_wen`=1,`rf_wa`=7,`rf_wd`=0xDEADBEEF next cycle; `hazard` for x7 high from issue until edge after that, then 0.
- Pipe write x3=0x11 same cycle as md response x9=0x22 -> cycle+1 writes x3=0x11, cycle+2 writes x9=0x22.
- Pipe writes every cycle for 4 cycles while md results x10,x11,x12 arrive -> FIFO fills, `md_resp_ready`=0 for third, then x10,x11,x12 drain in order after pipe stops.
- `md_issue` to x4 while busy[4]=1 -> `md_issue_ready`=0, busy state unchanged; x0 issue -> ready=1, no busy set.
- Pipe write x0=0xFF concurrent with FIFO head x6 -> x6 written that cycle, x0 never appears on `rf_*`.
